mipi_rgb_framer: RTL and testbench

Downstream stage of the MIPI CSI-2 receiver. Consumes the 24-bit RGB pixel stream with its start/valid strobes, tracks pixel coordinates, converts to RGB565, packs two pixels per 32-bit word and buffers words in a small FIFO with a ready/valid output toward the frame-buffer writer. The upstream stage has no backpressure, so the FIFO drops words when full and raises a sticky overflow flag.

---
 rtl/mipi_rgb_framer_pkg.sv | 20 ++
 rtl/mipi_rgb_framer_if.sv | 28 ++
 rtl/mipi_rgb_framer_fifo.sv | 48 ++++
 rtl/mipi_rgb_framer.sv | 155 +++++++++++++++
 tb/tb_mipi_rgb_framer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mipi_rgb_framer_pkg.sv
// Shared types and helpers for the MIPI RGB framer: widths, FIFO entry layout,
// and the RGB888 -> RGB565 truncating conversion.
package mipi_rgb_framer_pkg;

  localparam int unsigned WordW   = 32;
  localparam int unsigned PixW    = 24;
  localparam int unsigned Rgb565W = 16;
  localparam int unsigned CoordW  = 10;

  typedef struct packed {
    logic             sof;
    logic [WordW-1:0] word;
  } fifo_entry_t;

  // Keep the top bits of each channel: R5 G6 B5, no rounding.
  function automatic logic [Rgb565W-1:0] rgb565(input logic [PixW-1:0] pix);
    return {5'(pix[23:16] >> 3), 6'(pix[15:8] >> 2), 5'(pix[7:0] >> 3)};
  endfunction

endpackage

// File: rtl/mipi_rgb_framer_if.sv
// Pixel-in / word-out bundle of the framer; master is the framer side,
// slave is the CSI receiver plus frame-buffer writer side.
interface mipi_rgb_framer_if;
  import mipi_rgb_framer_pkg::*;

  logic [PixW-1:0]   iMIPI_DATA;
  logic              iMIPI_START;
  logic              iMIPI_DATAVALID;
  logic [WordW-1:0]  oWORD;
  logic              oWORD_SOF;
  logic              oWORD_VALID;
  logic              iWORD_READY;
  logic              oOVERFLOW;
  logic              oFRAME_DONE;
  logic [CoordW-1:0] oX;
  logic [CoordW-1:0] oY;

  modport master (
    input  iMIPI_DATA, iMIPI_START, iMIPI_DATAVALID, iWORD_READY,
    output oWORD, oWORD_SOF, oWORD_VALID, oOVERFLOW, oFRAME_DONE, oX, oY
  );

  modport slave (
    output iMIPI_DATA, iMIPI_START, iMIPI_DATAVALID, iWORD_READY,
    input  oWORD, oWORD_SOF, oWORD_VALID, oOVERFLOW, oFRAME_DONE, oX, oY
  );

endinterface

// File: rtl/mipi_rgb_framer_fifo.sv
// First-word-fall-through FIFO of {sof, word} entries; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module mipi_rgb_framer_fifo
  import mipi_rgb_framer_pkg::*;
#(
  parameter int unsigned pAW = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  fifo_entry_t wdata_i,
  input  logic        pop_i,
  output fifo_entry_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned Depth = 2 ** pAW;
  localparam int unsigned CntW  = pAW + 1;

  fifo_entry_t       mem_q [Depth];
  logic [pAW-1:0]    wr_q, rd_q;
  logic [CntW-1:0]   cnt_q;
  logic              pop_ok, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + pAW'(1);
      end
      if (pop_ok) rd_q <= rd_q + pAW'(1);
      cnt_q <= cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

endmodule

// File: rtl/mipi_rgb_framer.sv
// RGB888 pixel stream -> coordinate tracking -> RGB565 pair packing -> FWFT word FIFO.
// Optional crop window enabled with `define MIPI_RGB_FRAMER_CROP_EN.
module mipi_rgb_framer
  import mipi_rgb_framer_pkg::*;
#(
  parameter int unsigned pLINE_WIDTH   = 640,
  parameter int unsigned pFRAME_HEIGHT = 480,
  parameter int unsigned pFIFO_AW      = 4,
  parameter int unsigned pX0           = 0,
  parameter int unsigned pY0           = 0,
  parameter int unsigned pWIDTH        = 640,
  parameter int unsigned pHEIGHT       = 480
) (
  input logic               iMIPI_CLK,
  input logic               iRESET,
  mipi_rgb_framer_if.master bus
);

  localparam logic [CoordW-1:0] LastX  = CoordW'(pLINE_WIDTH - 1);
  localparam logic [CoordW-1:0] LastY  = CoordW'(pFRAME_HEIGHT - 1);
  localparam logic [CoordW-1:0] FrameH = CoordW'(pFRAME_HEIGHT);
  localparam logic [CoordW-1:0] WinX0  = CoordW'(pX0);
  localparam logic [CoordW-1:0] WinY0  = CoordW'(pY0);
  localparam logic [CoordW-1:0] WinW   = CoordW'(pWIDTH);
  localparam logic [CoordW-1:0] WinH   = CoordW'(pHEIGHT);
`ifdef MIPI_RGB_FRAMER_CROP_EN
  localparam bit CropOn = 1'b1;
`else
  localparam bit CropOn = 1'b0;
`endif

  logic [CoordW-1:0]  x_q, x_d, y_q, y_d;
  logic               half_q, half_d, sof_pend_q, sof_pend_d;
  logic [Rgb565W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic               pair_q, pair_d, pair_sof_q, pair_sof_d;
  logic [WordW-1:0]   word_q, word_d;
  logic               word_sof_q, word_sof_d, word_vld_q, word_vld_d;
  logic               done_q, done_d, ovf_q, ovf_d;

  logic               in_frame_c, in_win_c, pop_c, drop_c, full_c, empty_c;
  logic [Rgb565W-1:0] pix565_c;
  fifo_entry_t        rd_entry_c;

  // Modular subtraction keeps the window test a single unsigned compare per axis.
  assign in_frame_c = (y_q < FrameH);
  assign in_win_c   = CropOn ? (((x_q - WinX0) < WinW) && ((y_q - WinY0) < WinH)) : 1'b1;
  assign pix565_c   = rgb565(bus.iMIPI_DATA);
  assign pop_c      = ~empty_c & bus.iWORD_READY;
  assign drop_c     = word_vld_q & full_c & ~pop_c;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    half_d     = half_q;
    sof_pend_d = sof_pend_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    pair_d     = 1'b0;
    pair_sof_d = pair_sof_q;
    word_d     = word_q;
    word_sof_d = word_sof_q;
    word_vld_d = pair_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;

    if (pair_q) begin
      word_d     = {hi_q, lo_q};
      word_sof_d = pair_sof_q;
    end

    // START overrides a coincident pixel and any drop flagged in the same cycle.
    if (bus.iMIPI_START) begin
      x_d        = '0;
      y_d        = '0;
      half_d     = 1'b0;
      sof_pend_d = 1'b1;
      ovf_d      = 1'b0;
    end else begin
      if (drop_c) ovf_d = 1'b1;
      if (bus.iMIPI_DATAVALID) begin
        done_d = (x_q == LastX) && (y_q == LastY);
        if (x_q == LastX) begin
          x_d = '0;
          if (in_frame_c) y_d = y_q + CoordW'(1);
        end else begin
          x_d = x_q + CoordW'(1);
        end
        if (in_frame_c && in_win_c) begin
          if (half_q) begin
            hi_d       = pix565_c;
            pair_d     = 1'b1;
            pair_sof_d = sof_pend_q;
            sof_pend_d = 1'b0;
            half_d     = 1'b0;
          end else begin
            lo_d   = pix565_c;
            half_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge iMIPI_CLK or posedge iRESET) begin
    if (iRESET) begin
      x_q        <= '0;
      y_q        <= '0;
      half_q     <= 1'b0;
      sof_pend_q <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      pair_q     <= 1'b0;
      pair_sof_q <= 1'b0;
      word_q     <= '0;
      word_sof_q <= 1'b0;
      word_vld_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      half_q     <= half_d;
      sof_pend_q <= sof_pend_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      pair_q     <= pair_d;
      pair_sof_q <= pair_sof_d;
      word_q     <= word_d;
      word_sof_q <= word_sof_d;
      word_vld_q <= word_vld_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  mipi_rgb_framer_fifo #(.pAW(pFIFO_AW)) u_fifo (
    .clk_i   (iMIPI_CLK),
    .rst_i   (iRESET),
    .push_i  (word_vld_q),
    .wdata_i ('{sof: word_sof_q, word: word_q}),
    .pop_i   (pop_c),
    .rdata_o (rd_entry_c),
    .full_o  (full_c),
    .empty_o (empty_c)
  );

  assign bus.oWORD       = rd_entry_c.word;
  assign bus.oWORD_SOF   = rd_entry_c.sof;
  assign bus.oWORD_VALID = ~empty_c;
  assign bus.oOVERFLOW   = ovf_q;
  assign bus.oFRAME_DONE = done_q;
  assign bus.oX          = x_q;
  assign bus.oY          = y_q;

endmodule

// File: tb/tb_mipi_rgb_framer.sv
// Randomised bench for mipi_rgb_framer on a 4x2 frame with a 16-word FIFO,
// scored every cycle against a queue-based model of the framer behaviour.
module tb_mipi_rgb_framer;
  import mipi_rgb_framer_pkg::*;

  localparam int W = 4, H = 2, AW = 4, DEPTH = 16;
`ifdef MIPI_RGB_FRAMER_CROP_EN
  localparam int X0 = 2, Y0 = 1, CW = 2, CH = 1;
`else
  localparam int X0 = 0, Y0 = 0, CW = W, CH = H;
`endif
  localparam int WPF = (CW / 2) * CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mipi_rgb_framer_if bus ();

  mipi_rgb_framer #(
    .pLINE_WIDTH(W), .pFRAME_HEIGHT(H), .pFIFO_AW(AW),
    .pX0(X0), .pY0(Y0), .pWIDTH(CW), .pHEIGHT(CH)
  ) dut (
    .iMIPI_CLK(clk),
    .iRESET   (rst),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m565(input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
  endfunction

  // Model: words complete at an edge, enter the FIFO two edges later.
  logic [32:0] mq[$];
  logic [32:0] got[$];
  logic [32:0] p0, p1, newp;
  bit          p0v, p1v, newv, drop;
  int          mx, my;
  bit          mhalf, msofp, mdone, movf;
  logic [15:0] mlo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      p0v = 0; p1v = 0; p0 = '0; p1 = '0;
      mx = 0; my = 0; mhalf = 0; msofp = 0; mdone = 0; movf = 0; mlo = '0;
    end else begin
      drop = 0; newv = 0; newp = '0;
      if (bus.oWORD_VALID && bus.iWORD_READY) got.push_back({bus.oWORD_SOF, bus.oWORD});
      if (mq.size() > 0 && bus.iWORD_READY) void'(mq.pop_front());
      if (p1v) begin
        if (mq.size() < DEPTH) mq.push_back(p1);
        else drop = 1;
      end
      mdone = 0;
      if (bus.iMIPI_START) begin
        mx = 0; my = 0; mhalf = 0; msofp = 1; movf = 0;
      end else begin
        if (drop) movf = 1;
        if (bus.iMIPI_DATAVALID) begin
          if (my < H && mx >= X0 && mx < X0 + CW && my >= Y0 && my < Y0 + CH) begin
            if (!mhalf) begin
              mlo = m565(bus.iMIPI_DATA);
              mhalf = 1;
            end else begin
              newp = {msofp, m565(bus.iMIPI_DATA), mlo};
              newv = 1; msofp = 0; mhalf = 0;
            end
          end
          mdone = (mx == W - 1 && my == H - 1);
          if (mx == W - 1) begin
            mx = 0;
            if (my < H) my++;
          end else mx++;
        end
      end
      p1 = p0; p1v = p0v; p0 = newp; p0v = newv;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid", 64'(bus.oWORD_VALID), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("word", 64'(bus.oWORD), 64'(mq[0][31:0]));
        check("sof", 64'(bus.oWORD_SOF), 64'(mq[0][32]));
      end
      check("x", 64'(bus.oX), 64'(mx));
      check("y", 64'(bus.oY), 64'(my));
      check("frame_done", 64'(bus.oFRAME_DONE), 64'(mdone));
      check("overflow", 64'(bus.oOVERFLOW), 64'(movf));
    end
  end

  task automatic cyc(input bit s, input bit v, input logic [23:0] d);
    bus.iMIPI_START     = s;
    bus.iMIPI_DATAVALID = v;
    bus.iMIPI_DATA      = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 24'h0);
  endtask

  task automatic frame();
    cyc(1, 0, 24'h0);
    for (int i = 0; i < W * H; i++) cyc(0, 1, 24'($urandom));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 64'(bus.oWORD_VALID), 64'(0));
    check({tag, "_sof"}, 64'(bus.oWORD_SOF), 64'(0));
    check({tag, "_word"}, 64'(bus.oWORD), 64'(0));
    check({tag, "_ovf"}, 64'(bus.oOVERFLOW), 64'(0));
    check({tag, "_done"}, 64'(bus.oFRAME_DONE), 64'(0));
    check({tag, "_x"}, 64'(bus.oX), 64'(0));
    check({tag, "_y"}, 64'(bus.oY), 64'(0));
  endtask

  int mode;

  initial begin
    bus.iMIPI_START = 0; bus.iMIPI_DATAVALID = 0; bus.iMIPI_DATA = '0; bus.iWORD_READY = 1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    rst = 0;

    // Basic frame: pair timing, known words, end-of-frame pulse.
    bus.iWORD_READY = 1;
    got.delete();
    cyc(1, 0, 24'h0);
    cyc(0, 1, 24'hFFFFFF);
    cyc(0, 1, 24'h000000);
`ifndef MIPI_RGB_FRAMER_CROP_EN
    check("lat_n0", 64'(bus.oWORD_VALID), 64'(0));
    idle(1);
    check("lat_n1", 64'(bus.oWORD_VALID), 64'(0));
    idle(1);
    check("lat_n2", 64'(bus.oWORD_VALID), 64'(1));
    check("first_word", 64'(bus.oWORD), 64'(32'h0000FFFF));
    check("first_sof", 64'(bus.oWORD_SOF), 64'(1));
`endif
    cyc(0, 1, 24'hF8FC00);
    cyc(0, 1, 24'h000000);
    cyc(0, 1, 24'h123456);
    cyc(0, 1, 24'hABCDEF);
    cyc(0, 1, 24'hFFFFFF);
    cyc(0, 1, 24'hF8FC00);
    check("done_pulse", 64'(bus.oFRAME_DONE), 64'(1));
    check("eof_x", 64'(bus.oX), 64'(0));
    check("eof_y", 64'(bus.oY), 64'(2));
    idle(1);
    check("done_drop", 64'(bus.oFRAME_DONE), 64'(0));
    idle(5);
    check("model_565", 64'(m565(24'hF8FC00)), 64'(16'hFFE0));
`ifdef MIPI_RGB_FRAMER_CROP_EN
    check("crop_count", 64'(got.size()), 64'(1));
    if (got.size() >= 1) check("crop_word", 64'(got[0]), 64'({1'b1, 32'hFFE0FFFF}));
`else
    check("frame_count", 64'(got.size()), 64'(4));
    if (got.size() >= 4) begin
      check("word1", 64'(got[1]), 64'({1'b0, 32'h0000FFE0}));
      check("word2", 64'(got[2]), 64'({1'b0, 32'hAE7D11AA}));
      check("word3", 64'(got[3]), 64'({1'b0, 32'hFFE0FFFF}));
    end
`endif

    // Overflow: fill the FIFO with ready low, one more word is dropped.
    bus.iWORD_READY = 0;
    for (int f = 0; f < DEPTH / WPF; f++) frame();
    frame();
    idle(3);
    check("ovf_set", 64'(bus.oOVERFLOW), 64'(1));
    cyc(1, 0, 24'h0);
    check("ovf_clr", 64'(bus.oOVERFLOW), 64'(0));
    got.delete();
    bus.iWORD_READY = 1;
    idle(DEPTH + 3);
    check("drain_count", 64'(got.size()), 64'(DEPTH));
    if (got.size() >= 1) check("drain_sof0", 64'(got[0][32]), 64'(1));

    // START coincident with a pixel, after a partial word.
    got.delete();
    cyc(1, 0, 24'h0);
    cyc(0, 1, 24'h112233);
    cyc(0, 1, 24'h445566);
    cyc(0, 1, 24'h778899);
    cyc(1, 1, 24'hCAFE00);
    check("restart_x", 64'(bus.oX), 64'(0));
    check("restart_y", 64'(bus.oY), 64'(0));
    cyc(0, 1, 24'hFFFFFF);
    cyc(0, 1, 24'h000000);
    idle(4);
`ifndef MIPI_RGB_FRAMER_CROP_EN
    check("restart_count", 64'(got.size()), 64'(2));
    if (got.size() >= 2) check("restart_word", 64'(got[1]), 64'({1'b1, 32'h0000FFFF}));
`endif

    // Asynchronous reset with words buffered.
    bus.iWORD_READY = 0;
    cyc(1, 0, 24'h0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 24'($urandom));
    idle(3);
`ifndef MIPI_RGB_FRAMER_CROP_EN
    check("pre_rst_valid", 64'(bus.oWORD_VALID), 64'(1));
`endif
    #2 rst = 1;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    rst = 0;
    got.delete();
    bus.iWORD_READY = 1;
    cyc(0, 1, 24'hFFFFFF);
    cyc(0, 1, 24'h000000);
    idle(4);
`ifndef MIPI_RGB_FRAMER_CROP_EN
    check("nostart_count", 64'(got.size()), 64'(1));
    if (got.size() >= 1) check("nostart_word", 64'(got[0]), 64'({1'b0, 32'h0000FFFF}));
`endif

    // Random traffic with varying backpressure.
    mode = 0;
    for (int i = 0; i < 1200; i++) begin
      if (i % 100 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0:       bus.iWORD_READY = 1'b1;
        1:       bus.iWORD_READY = ($urandom_range(0, 3) != 0);
        default: bus.iWORD_READY = ($urandom_range(0, 7) == 0);
      endcase
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7, 24'($urandom));
    end
    bus.iWORD_READY = 1;
    idle(DEPTH + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
